// File: rtl/driver_cntrl_mch.sv
// Multi-channel driver control/status register block: per-channel address push,
// thresholds, program sequencing FSM, sticky W1C events and a combined interrupt.
//
// state  | meaning
// IDLE   | channel stopped, waiting for run
// ARMED  | run set, waiting for addr FIFO fill >= threshold
// ACTIVE | program executing
// ERROR  | FIFO fault seen while active, held until run is written 0
// DONE   | program complete, run=0 -> IDLE, run=1 again -> re-arm
module driver_cntrl_mch #(
    parameter int NUM_CH          = 4,
    parameter int CNT_W           = 16,
    parameter int DEF_ADDR_THRESH = 820,
    parameter int DEF_VCTR_THRESH = 7500
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [11:0]               slave_awaddr,
    input  logic                      slave_wr,
    input  logic [31:0]               slave_data_in,
    input  logic [11:0]               slave_araddr,
    output logic [31:0]               slave_data_out,
    output logic [31:0]               addr_fifo_din,
    output logic [NUM_CH-1:0]         addr_fifo_wr,
    input  logic [NUM_CH*CNT_W-1:0]   words_in_addr_fifo,
    input  logic [NUM_CH*4-1:0]       fifo_err,
    input  logic [NUM_CH-1:0]         end_in,
    output logic [NUM_CH*CNT_W-1:0]   addr_fifo_threshold,
    output logic [NUM_CH*CNT_W-1:0]   vector_fifo_threshold,
    output logic [NUM_CH-1:0]         active_program,
    output logic [NUM_CH-1:0]         program_start,
    output logic [NUM_CH-1:0]         program_error,
    output logic                      irq
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_ERROR  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    state_e            state_q  [NUM_CH];
    state_e            state_d  [NUM_CH];
    logic [2:0]        irq_en_q [NUM_CH];
    logic [2:0]        irq_en_d [NUM_CH];
    logic [2:0]        ev_q     [NUM_CH];
    logic [2:0]        ev_d     [NUM_CH];
    logic [CNT_W-1:0]  ath_q    [NUM_CH];
    logic [CNT_W-1:0]  ath_d    [NUM_CH];
    logic [CNT_W-1:0]  vth_q    [NUM_CH];
    logic [CNT_W-1:0]  vth_d    [NUM_CH];
    logic [31:0]       last_q   [NUM_CH];
    logic [31:0]       last_d   [NUM_CH];
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] fifo_wr_q, fifo_wr_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              irq_q, irq_d;

    logic [NUM_CH-1:0] wr_push, wr_ctrl, wr_ath, wr_vth, wr_ev;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] start;
    logic [4:0]        w_off, r_off;
    logic [31:0]       wd;

    assign w_off = slave_awaddr[4:0];
    assign r_off = slave_araddr[4:0];
    assign wd    = slave_data_in;

    always_comb begin
        wr_push = '0;
        wr_ctrl = '0;
        wr_ath  = '0;
        wr_vth  = '0;
        wr_ev   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (slave_wr && slave_awaddr[11:9] == 3'b000 && slave_awaddr[8:5] == 4'(c)) begin
                wr_push[c] = (w_off == 5'h00);
                wr_ctrl[c] = (w_off == 5'h04);
                wr_ath[c]  = (w_off == 5'h08);
                wr_vth[c]  = (w_off == 5'h0C);
                wr_ev[c]   = (w_off == 5'h14);
            end
        end
    end

    always_comb begin
        run_d     = run_q;
        fifo_wr_d = '0;
        din_d     = din_q;
        start     = '0;
        pending   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]  = state_q[c];
            irq_en_d[c] = irq_en_q[c];
            ath_d[c]    = wr_ath[c] ? wd[CNT_W-1:0] : ath_q[c];
            vth_d[c]    = wr_vth[c] ? wd[CNT_W-1:0] : vth_q[c];
            last_d[c]   = last_q[c];
            // W1C clear first so a same-cycle event set below takes precedence
            ev_d[c]     = ev_q[c] & ~(wr_ev[c] ? wd[2:0] : 3'b000);
            pending[c]  = |(ev_q[c] & irq_en_q[c]);

            if (wr_push[c]) begin
                fifo_wr_d[c] = 1'b1;
                din_d        = wd;
                last_d[c]    = wd;
            end
            if (wr_ctrl[c]) begin
                run_d[c]    = wd[0];
                irq_en_d[c] = wd[6:4];
            end

            case (state_q[c])
                ST_IDLE: begin
                    if (run_q[c]) state_d[c] = ST_ARMED;
                end
                ST_ARMED: begin
                    if (wr_ctrl[c] && wd[2]) begin
                        state_d[c] = ST_IDLE;
                        run_d[c]   = 1'b0;
                        ev_d[c][2] = 1'b1;
                    end else if (words_in_addr_fifo[c*CNT_W +: CNT_W] >= ath_q[c]) begin
                        state_d[c] = ST_ACTIVE;
                        start[c]   = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (|fifo_err[c*4 +: 4]) begin
                        state_d[c] = ST_ERROR;
                        ev_d[c][1] = 1'b1;
                    end else if (wr_ctrl[c] && wd[2]) begin
                        state_d[c] = ST_IDLE;
                        run_d[c]   = 1'b0;
                        ev_d[c][2] = 1'b1;
                    end else if (end_in[c] || (wr_ctrl[c] && wd[1])) begin
                        state_d[c] = ST_DONE;
                        ev_d[c][0] = 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (wr_ctrl[c] && !wd[0]) state_d[c] = ST_IDLE;
                end
                ST_DONE: begin
                    if (wr_ctrl[c] && !wd[0])              state_d[c] = ST_IDLE;
                    else if (wr_ctrl[c] && wd[0] && run_q[c]) state_d[c] = ST_ARMED;
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end
        irq_d = |pending;
    end

    always_comb begin
        rdata_d = '0;
        if (slave_araddr == 12'h400) begin
            rdata_d = 32'(pending);
        end else if (slave_araddr == 12'h404) begin
            rdata_d = {16'h0002, 16'(NUM_CH)};
        end else if (slave_araddr[11:9] == 3'b000) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (slave_araddr[8:5] == 4'(c)) begin
                    case (r_off)
                        5'h00: rdata_d = last_q[c];
                        5'h04: rdata_d = {25'b0, irq_en_q[c], 3'b000, run_q[c]};
                        5'h08: rdata_d = 32'(ath_q[c]);
                        5'h0C: rdata_d = 32'(vth_q[c]);
                        5'h10: rdata_d = {16'(words_in_addr_fifo[c*CNT_W +: CNT_W]), 6'b0,
                                          state_q[c] == ST_ERROR, state_q[c] == ST_ACTIVE,
                                          5'b0, state_q[c]};
                        5'h14: rdata_d = {29'b0, ev_q[c]};
                        default: rdata_d = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q     <= '0;
            fifo_wr_q <= '0;
            din_q     <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= ST_IDLE;
                irq_en_q[c] <= '0;
                ev_q[c]     <= '0;
                ath_q[c]    <= CNT_W'(DEF_ADDR_THRESH);
                vth_q[c]    <= CNT_W'(DEF_VCTR_THRESH);
                last_q[c]   <= '0;
            end
        end else begin
            run_q     <= run_d;
            fifo_wr_q <= fifo_wr_d;
            din_q     <= din_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= state_d[c];
                irq_en_q[c] <= irq_en_d[c];
                ev_q[c]     <= ev_d[c];
                ath_q[c]    <= ath_d[c];
                vth_q[c]    <= vth_d[c];
                last_q[c]   <= last_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            addr_fifo_threshold[c*CNT_W +: CNT_W]   = ath_q[c];
            vector_fifo_threshold[c*CNT_W +: CNT_W] = vth_q[c];
            active_program[c] = (state_q[c] == ST_ACTIVE);
            program_error[c]  = (state_q[c] == ST_ERROR);
        end
    end

    assign program_start  = start;
    assign addr_fifo_wr   = fifo_wr_q;
    assign addr_fifo_din  = din_q;
    assign slave_data_out = rdata_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_driver_cntrl_mch.sv
// Directed bench for driver_cntrl_mch: push path, threshold start, error/abort
// sequencing, interrupt timing and asynchronous reset.
module tb_driver_cntrl_mch;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] slave_awaddr;
    logic        slave_wr;
    logic [31:0] slave_data_in;
    logic [11:0] slave_araddr;
    logic [31:0] slave_data_out;
    logic [31:0] addr_fifo_din;
    logic [3:0]  addr_fifo_wr;
    logic [63:0] words_in_addr_fifo;
    logic [15:0] fifo_err;
    logic [3:0]  end_in;
    logic [63:0] addr_fifo_threshold;
    logic [63:0] vector_fifo_threshold;
    logic [3:0]  active_program;
    logic [3:0]  program_start;
    logic [3:0]  program_error;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    driver_cntrl_mch dut (
        .clk                   (clk),
        .reset                 (reset),
        .slave_awaddr          (slave_awaddr),
        .slave_wr              (slave_wr),
        .slave_data_in         (slave_data_in),
        .slave_araddr          (slave_araddr),
        .slave_data_out        (slave_data_out),
        .addr_fifo_din         (addr_fifo_din),
        .addr_fifo_wr          (addr_fifo_wr),
        .words_in_addr_fifo    (words_in_addr_fifo),
        .fifo_err              (fifo_err),
        .end_in                (end_in),
        .addr_fifo_threshold   (addr_fifo_threshold),
        .vector_fifo_threshold (vector_fifo_threshold),
        .active_program        (active_program),
        .program_start         (program_start),
        .program_error         (program_error),
        .irq                   (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [11:0] a, input logic [31:0] d);
        slave_awaddr  = a;
        slave_data_in = d;
        slave_wr      = 1'b1;
        tick(1);
        slave_wr      = 1'b0;
    endtask

    task automatic reg_rd(input logic [11:0] a, output logic [31:0] d);
        slave_araddr = a;
        tick(1);
        d = slave_data_out;
    endtask

    logic [31:0] rd;
    int          start_cnt;
    int          start_at;

    initial begin
        reset              = 1'b1;
        slave_awaddr       = '0;
        slave_wr           = 1'b0;
        slave_data_in      = '0;
        slave_araddr       = '0;
        words_in_addr_fifo = '0;
        fifo_err           = '0;
        end_in             = '0;
        #23;
        check_val("rst_irq",     64'(irq), 64'd0);
        check_val("rst_fifo_wr", 64'(addr_fifo_wr), 64'd0);
        check_val("rst_rdata",   64'(slave_data_out), 64'd0);
        check_val("rst_ath",     addr_fifo_threshold, {4{16'd820}});
        check_val("rst_vth",     vector_fifo_threshold, {4{16'd7500}});
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1);

        // push to ch2
        reg_wr(12'h040, 32'hDEADBEEF);
        check_val("push_wr",  64'(addr_fifo_wr), 64'h4);
        check_val("push_din", 64'(addr_fifo_din), 64'hDEADBEEF);
        tick(1);
        check_val("push_wr_off", 64'(addr_fifo_wr), 64'h0);
        reg_rd(12'h040, rd);
        check_val("push_rb", 64'(rd), 64'hDEADBEEF);
        reg_rd(12'h000, rd);
        check_val("ch0_last", 64'(rd), 64'h0);

        // ch0 threshold start
        reg_wr(12'h008, 32'd10);
        reg_wr(12'h004, 32'h1);
        start_cnt = 0;
        start_at  = -1;
        for (int f = 0; f <= 12; f++) begin
            words_in_addr_fifo[15:0] = 16'(f);
            #2;
            if (program_start[0]) begin
                start_cnt++;
                start_at = f;
            end
            @(posedge clk);
            #1;
        end
        check_val("start_cnt", 64'(start_cnt), 64'd1);
        check_val("start_at",  64'(start_at), 64'd10);
        reg_rd(12'h010, rd);
        check_val("ch0_status", 64'(rd), 64'h000C_0102);
        check_val("ch0_active", 64'(active_program), 64'h1);

        // ch1 error beats end
        words_in_addr_fifo[31:16] = 16'd1000;
        reg_wr(12'h024, 32'h21);
        tick(3);
        check_val("ch1_active", 64'(active_program[1]), 64'd1);
        fifo_err[5] = 1'b1;
        end_in[1]   = 1'b1;
        tick(1);
        fifo_err = '0;
        end_in   = '0;
        check_val("ch1_err",     64'(program_error[1]), 64'd1);
        check_val("irq_lag",     64'(irq), 64'd0);
        tick(1);
        check_val("irq_set",     64'(irq), 64'd1);
        reg_rd(12'h034, rd);
        check_val("ch1_ev",      64'(rd), 64'h2);
        reg_rd(12'h030, rd);
        check_val("ch1_status",  64'(rd), 64'h03E8_0203);
        reg_rd(12'h400, rd);
        check_val("pending",     64'(rd), 64'h2);
        reg_wr(12'h024, 32'h20);
        reg_rd(12'h030, rd);
        check_val("ch1_idle",    64'(rd), 64'h03E8_0000);
        check_val("irq_hold",    64'(irq), 64'd1);
        reg_wr(12'h034, 32'h2);
        check_val("irq_w1c_lag", 64'(irq), 64'd1);
        tick(1);
        check_val("irq_clr",     64'(irq), 64'd0);

        // ch3 abort from ARMED
        reg_wr(12'h064, 32'h1);
        tick(1);
        reg_rd(12'h070, rd);
        check_val("ch3_armed", 64'(rd), 64'h1);
        reg_wr(12'h064, 32'h5);
        reg_rd(12'h064, rd);
        check_val("ch3_run",   64'(rd), 64'h0);
        reg_rd(12'h074, rd);
        check_val("ch3_ev",    64'(rd), 64'h4);
        fifo_err[15:12] = 4'hF;
        tick(2);
        fifo_err = '0;
        reg_rd(12'h074, rd);
        check_val("ch3_ev_idle",  64'(rd), 64'h4);
        reg_rd(12'h070, rd);
        check_val("ch3_state",    64'(rd), 64'h0);
        check_val("ch3_no_err",   64'(program_error), 64'h0);
        check_val("irq_masked",   64'(irq), 64'd0);

        // async reset with ch0 and ch2 active
        words_in_addr_fifo[47:32] = 16'd900;
        reg_wr(12'h044, 32'h1);
        tick(3);
        check_val("two_active", 64'(active_program), 64'h5);
        #2;
        reset = 1'b1;
        #1;
        check_val("ar_active", 64'(active_program), 64'h0);
        check_val("ar_start",  64'(program_start), 64'h0);
        check_val("ar_fifowr", 64'(addr_fifo_wr), 64'h0);
        check_val("ar_ath",    addr_fifo_threshold, {4{16'd820}});
        @(posedge clk);
        #1;
        reset = 1'b0;
        reg_rd(12'h008, rd);
        check_val("ar_ath_rb", 64'(rd), 64'd820);
        reg_rd(12'h00C, rd);
        check_val("ar_vth_rb", 64'(rd), 64'd7500);
        reg_rd(12'h404, rd);
        check_val("id_reg",    64'(rd), 64'h0002_0004);
        reg_rd(12'h300, rd);
        check_val("unmapped",  64'(rd), 64'h0);
        check_val("post_active", 64'(active_program), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
